uart_digit_rx: RTL and testbench

Serial-to-display front end: receives 8E1 UART frames on a single line and maintains the four 4-bit BCD digit registers that feed the four-digit multiplexed seven-segment driver. Each correctly framed byte carrying a value 0–9 shifts in as a new rightmost digit. Byte 0x0C clears the display. Parity and framing faults are flagged and never disturb the displayed digits. It sits between the board's RX pin and the `digit1..digit4` inputs of the display top level, in the display's clock domain.

---
 rtl/uart_digit_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_digit_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_digit_rx.sv
// 8E1 UART receiver that feeds four BCD display digits. Bytes 0x00-0x09 shift
// in as a new rightmost digit, 0x0C clears the display, other values are ignored.
module uart_digit_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       rx,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(HALF - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic [2:0]    state;
    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          parity_ok;

    // Even parity: data plus parity bit must hold an even number of ones.
    assign parity_ok = ~(^{shreg, par_bit});
    assign busy      = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= IDLE;
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            digit1     <= '0;
            digit2     <= '0;
            digit3     <= '0;
            digit4     <= '0;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx;
            rx_s       <= sync1;
            byte_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                // Mid-bit check of the start bit filters short glitches.
                START: begin
                    if (cnt == LAST_HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == LAST_BIT) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                PARITY: begin
                    if (cnt == LAST_BIT) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Leaving at mid-stop lets a following start bit be seen on time.
                STOP: begin
                    if (cnt == LAST_BIT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (parity_ok) begin
                                byte_valid <= 1'b1;
                                parity_err <= 1'b0;
                                frame_err  <= 1'b0;
                                if (shreg <= 8'h09) begin
                                    digit1 <= digit2;
                                    digit2 <= digit3;
                                    digit3 <= digit4;
                                    digit4 <= shreg[3:0];
                                end else if (shreg == 8'h0C) begin
                                    digit1 <= '0;
                                    digit2 <= '0;
                                    digit3 <= '0;
                                    digit4 <= '0;
                                end
                            end else begin
                                parity_err <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            if (!parity_ok) begin
                                parity_err <= 1'b1;
                            end
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_digit_rx.sv
// Directed self-checking bench for uart_digit_rx with 16 clocks per bit.
module tb_uart_digit_rx;

    localparam int CPB = 16;
    // Stop sample lands 2 sync edges + HALF + 10 bit periods after the first capture edge.
    localparam int STOP_OFFSET = 1 + 2 + CPB / 2 + 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       byte_valid, parity_err, frame_err, busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulse_count = 0;
    int last_pulse_cyc = -1;
    int fall_cyc = 0;

    uart_digit_rx #(.CLKS_PER_BIT(CPB)) dut (
        .Clk(clk),
        .reset(reset),
        .rx(rx),
        .digit1(digit1),
        .digit2(digit2),
        .digit3(digit3),
        .digit4(digit4),
        .byte_valid(byte_valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            pulse_count++;
            last_pulse_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one frame from a falling clock edge and returns on a falling edge.
    task automatic send_frame(input logic [7:0] data, input logic flip_par, input logic stop_val);
        fall_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = (^data) ^ flip_par;
        repeat (CPB) @(negedge clk);
        rx = stop_val;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_digits: got %h required 0000", {digit1, digit2, digit3, digit4});
        end
        total++;
        if ({byte_valid, parity_err, frame_err} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b required 000", {byte_valid, parity_err, frame_err});
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy: got %b required 0", busy);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_digits();
        logic [7:0]  bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [15:0] exp   [4] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};
        int start_count;
        start_count = pulse_count;
        for (int i = 0; i < 4; i++) begin
            send_frame(bytes[i], 1'b0, 1'b1);
            total++;
            if ({digit1, digit2, digit3, digit4} !== exp[i]) begin
                bad++;
                $display("[TB] FAIL basic_digits_%0d: got %h required %h", i, {digit1, digit2, digit3, digit4}, exp[i]);
            end
            total++;
            if (last_pulse_cyc !== fall_cyc + STOP_OFFSET) begin
                bad++;
                $display("[TB] FAIL basic_pulse_edge_%0d: got cycle %0d required %0d", i, last_pulse_cyc, fall_cyc + STOP_OFFSET);
            end
        end
        total++;
        if (pulse_count !== start_count + 4) begin
            bad++;
            $display("[TB] FAIL basic_pulse_count: got %0d required %0d", pulse_count - start_count, 4);
        end
        send_frame(8'h09, 1'b0, 1'b1);
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h2349) begin
            bad++;
            $display("[TB] FAIL basic_digit_9: got %h required 2349", {digit1, digit2, digit3, digit4});
        end
    endtask

    task automatic test_parity_error();
        int start_count;
        start_count = pulse_count;
        send_frame(8'h05, 1'b1, 1'b1);
        total++;
        if (parity_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL parity_err_set: got %b required 1", parity_err);
        end
        total++;
        if (pulse_count !== start_count) begin
            bad++;
            $display("[TB] FAIL parity_no_pulse: got %0d pulses required 0", pulse_count - start_count);
        end
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h2349) begin
            bad++;
            $display("[TB] FAIL parity_digits_kept: got %h required 2349", {digit1, digit2, digit3, digit4});
        end
        send_frame(8'h06, 1'b0, 1'b1);
        total++;
        if (parity_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL parity_err_clear: got %b required 0", parity_err);
        end
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h3496) begin
            bad++;
            $display("[TB] FAIL parity_recover_digits: got %h required 3496", {digit1, digit2, digit3, digit4});
        end
    endtask

    task automatic test_frame_break();
        int start_count;
        int busy_low;
        start_count = pulse_count;
        busy_low = 0;
        send_frame(8'h07, 1'b0, 1'b0);
        rx = 1'b0;
        for (int i = 0; i < 40 * CPB; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_low++;
        end
        total++;
        if (busy_low !== 0) begin
            bad++;
            $display("[TB] FAIL break_busy: got %0d idle cycles required 0", busy_low);
        end
        total++;
        if ({frame_err, parity_err} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL frame_err_set: got frame/parity %b required 10", {frame_err, parity_err});
        end
        total++;
        if (pulse_count !== start_count || {digit1, digit2, digit3, digit4} !== 16'h3496) begin
            bad++;
            $display("[TB] FAIL break_no_rx: got %0d pulses digits %h required 0 pulses digits 3496",
                     pulse_count - start_count, {digit1, digit2, digit3, digit4});
        end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        send_frame(8'h08, 1'b0, 1'b1);
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL frame_err_clear: got %b required 0", frame_err);
        end
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h4968) begin
            bad++;
            $display("[TB] FAIL frame_recover_digits: got %h required 4968", {digit1, digit2, digit3, digit4});
        end
    endtask

    task automatic test_clear_ignore();
        int start_count;
        start_count = pulse_count;
        send_frame(8'h0C, 1'b0, 1'b1);
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h0000 || pulse_count !== start_count + 1) begin
            bad++;
            $display("[TB] FAIL clear_digits: got %h with %0d pulses required 0000 with 1 pulse",
                     {digit1, digit2, digit3, digit4}, pulse_count - start_count);
        end
        send_frame(8'h3A, 1'b0, 1'b1);
        total++;
        if (pulse_count !== start_count + 2) begin
            bad++;
            $display("[TB] FAIL ignored_pulse: got %0d pulses required 2", pulse_count - start_count);
        end
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL ignored_digits: got %h required 0000", {digit1, digit2, digit3, digit4});
        end
    endtask

    task automatic test_glitch_reset();
        int start_count;
        start_count = pulse_count;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total++;
        if ({busy, parity_err, frame_err} !== 3'b000 || pulse_count !== start_count) begin
            bad++;
            $display("[TB] FAIL glitch_ignored: got busy/perr/ferr %b pulses %0d required 000 pulses 0",
                     {busy, parity_err, frame_err}, pulse_count - start_count);
        end

        send_frame(8'h05, 1'b0, 1'b1);
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h0005) begin
            bad++;
            $display("[TB] FAIL pre_reset_digits: got %h required 0005", {digit1, digit2, digit3, digit4});
        end

        // Start 0x02 and abort it halfway through data bit 4.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 1) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midframe_busy: got %b required 1", busy);
        end
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        total++;
        if ({digit1, digit2, digit3, digit4, busy, byte_valid, parity_err, frame_err} !== 20'h00000) begin
            bad++;
            $display("[TB] FAIL midframe_reset: got digits %h busy/bv/perr/ferr %b required 0000 0000",
                     {digit1, digit2, digit3, digit4}, {busy, byte_valid, parity_err, frame_err});
        end
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        start_count = pulse_count;
        send_frame(8'h03, 1'b0, 1'b1);
        total++;
        if ({digit1, digit2, digit3, digit4} !== 16'h0003 || pulse_count !== start_count + 1) begin
            bad++;
            $display("[TB] FAIL post_reset_rx: got %h with %0d pulses required 0003 with 1 pulse",
                     {digit1, digit2, digit3, digit4}, pulse_count - start_count);
        end
        total++;
        if (last_pulse_cyc !== fall_cyc + STOP_OFFSET) begin
            bad++;
            $display("[TB] FAIL post_reset_pulse_edge: got cycle %0d required %0d", last_pulse_cyc, fall_cyc + STOP_OFFSET);
        end
    endtask

    initial begin
        test_reset();
        test_basic_digits();
        test_parity_error();
        test_frame_break();
        test_clear_ignore();
        test_glitch_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
